mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-requester arbiter that shares the single core memory bus between the fetch stage (instruction port) and the memory stage (data port) of the five-stage pipeline. It accepts one request at a time, registers it onto the bus, and waits for its response. It then routes the response back to the owning stage. It also drops the response of an instruction fetch killed by a pipeline flush.

## Interface
- `ADDR_W`, 64, address width in bits
- `DATA_W`, 64, data width in bits; strobe width is `DATA_W/8`
- `clk`  in  1  clock, all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `i_req_valid`  in  1  fetch request pending; fields held stable until accepted
- `i_req_addr`  in  ADDR_W  fetch address (read, 4-byte, size 3'b010)
- `i_req_ready`  out  1  fetch request accepted this cycle
- `i_resp_valid`  out  1  fetch read data valid (single-cycle pulse)
- `i_resp_data`  out  DATA_W  fetch read data
- `d_req_valid`  in  1  data request pending; fields held stable until accepted
- `d_req_addr`  in  ADDR_W  data address
- `d_req_write`  in  1  1 = store, 0 = load
- `d_req_size`  in  3  log2 access bytes
- `d_req_strobe`  in  DATA_W/8  byte enables (stores)
- `d_req_wdata`  in  DATA_W  store data
- `d_req_ready`  out  1  data request accepted this cycle
- `d_resp_valid`  out  1  data transaction complete (single-cycle pulse)
- `d_resp_data`  out  DATA_W  load data
- `flush`  in  1  pipeline redirect; kills the in-flight or newly offered fetch
- `m_req_valid`, `m_req_addr`, `m_req_write`, `m_req_size`, `m_req_strobe`, `m_req_wdata`  out  1/ADDR_W/1/3/DATA_W/8/DATA_W  registered bus request
- `m_req_ready`  in  1  bus accepts request
- `m_resp_valid`  in  1  bus response valid
- `m_resp_data`  in  DATA_W  bus response data

## Operation
- States: IDLE, REQ, WAIT. Registers: `owner` (I/D), `drop`, request holding register, `last_grant` (RR build only).
- IDLE: eligible requesters are `d_req_valid` and `i_req_valid & ~flush`. When one or more are eligible, grant a single winner. The winner's `*_req_ready` is asserted combinationally in this cycle. Latch its fields (instruction grant: write=0, size=3'b010, strobe=0, wdata=0) and `owner`. Go to REQ.
- REQ: `m_req_valid`=1 driven from the holding register. On `m_req_ready`, go to WAIT. `m_resp_valid` is ignored in REQ; the bus never responds in the accept cycle.
- WAIT: on `m_resp_valid`, pulse the owner's `*_resp_valid` with `m_resp_data` passed through combinationally, then go to IDLE. When `owner`=I and `drop`=1, suppress the pulse.
- Flush: `flush` in REQ/WAIT with `owner`=I sets `drop`. The bus transaction still completes. `drop` clears on entry to IDLE. `flush` has no effect on data transactions.
- Single outstanding transaction. A requester arriving while busy waits until IDLE.
- Non-owner `*_resp_valid` is always 0. `*_resp_data` is `m_resp_data` on both ports; it is qualified by valid only.

## Timing
- Reset (async, `reset`=0): state IDLE, `drop`=0, `owner`=I, holding register 0, `last_grant`=I. All outputs 0 except the pass-through data ports.
- Accept to `m_req_valid`: 1 cycle. `m_req_*` change only on the IDLE→REQ edge.
- Minimum cycle count from request offered to response: accept at t, `m_req_valid` at t+1, ready at t+1, WAIT at t+2, response at t+2 or later.
- Back-to-back throughput: the next grant is possible in the cycle after the response, because IDLE is a one-cycle minimum.
- Reset asserted mid-transaction: returns immediately to IDLE and drops any pending response. Post-reset bus contract: the bus is reset on the same signal.

## Configuration
- `ARB_RR_EN` defined: on a tie in IDLE, grant the requester not in `last_grant`. `last_grant` updates on every grant.
- `ARB_RR_EN` undefined: fixed priority, data over instruction. `last_grant` register is absent.

## Test plan
- Lone fetch, addr 0x8000_0000, bus ready immediately, response 0x0000_0013 after 2 cycles -> `i_req_ready` at t, `m_req_valid` t+1, `i_resp_valid`=1 with data 0x13 exactly once, `d_resp_valid` never.
- Simultaneous I and D requests (store 0x8000_1000, strobe 0xFF, wdata 0xDEADBEEF) -> fixed build: D granted first, I second. `ARB_RR_EN` build: D first, then the next tie goes to I.
- Flush during WAIT of a fetch -> bus response consumed, `i_resp_valid` stays 0, the next fetch returns normally with `drop` cleared.
- `flush`=1 in IDLE with only `i_req_valid` -> no grant, `m_req_valid` stays 0. The grant happens the cycle after `flush` drops.
- `m_req_ready` held low 5 cycles -> `m_req_*` stable throughout, no new `*_req_ready`.
- `reset` asserted in WAIT -> state IDLE and `m_req_valid`=0 asynchronously. A later `m_resp_valid` produces no response pulse.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter for the shared core memory bus: one outstanding transaction,
// registered bus request, flush-killed fetch responses dropped. Define ARB_RR_EN for round-robin tie-break.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  input  logic [ADDR_W-1:0]     i_req_addr,
  output logic                  i_req_ready,
  output logic                  i_resp_valid,
  output logic [DATA_W-1:0]     i_resp_data,
  input  logic                  d_req_valid,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic                  d_req_write,
  input  logic [2:0]            d_req_size,
  input  logic [DATA_W/8-1:0]   d_req_strobe,
  input  logic [DATA_W-1:0]     d_req_wdata,
  output logic                  d_req_ready,
  output logic                  d_resp_valid,
  output logic [DATA_W-1:0]     d_resp_data,
  input  logic                  flush,
  output logic                  m_req_valid,
  output logic [ADDR_W-1:0]     m_req_addr,
  output logic                  m_req_write,
  output logic [2:0]            m_req_size,
  output logic [DATA_W/8-1:0]   m_req_strobe,
  output logic [DATA_W-1:0]     m_req_wdata,
  input  logic                  m_req_ready,
  input  logic                  m_resp_valid,
  input  logic [DATA_W-1:0]     m_resp_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t state, state_nxt;
  owner_t owner;
  logic   drop, drop_nxt;
  logic   i_elig, d_elig, grant_i, grant_d, grant_any;

  assign i_elig    = i_req_valid & ~flush;
  assign d_elig    = d_req_valid;
  assign grant_any = grant_i | grant_d;

`ifdef ARB_RR_EN
  owner_t last_grant;

  // On a tie, favour whichever requester did not win the previous grant.
  always_comb begin
    grant_d = d_elig & (~i_elig | (last_grant == OWN_I));
    grant_i = i_elig & ~grant_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_grant <= OWN_I;
    else if (state == S_IDLE && grant_any)
      last_grant <= grant_d ? OWN_D : OWN_I;
  end
`else
  always_comb begin
    grant_d = d_elig;
    grant_i = i_elig & ~d_elig;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    drop_nxt     = drop;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    m_req_valid  = 1'b0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        drop_nxt    = 1'b0;
        i_req_ready = grant_i;
        d_req_ready = grant_d;
        if (grant_any)
          state_nxt = S_REQ;
      end
      S_REQ: begin
        m_req_valid = 1'b1;
        if (flush && owner == OWN_I)
          drop_nxt = 1'b1;
        if (m_req_ready)
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (flush && owner == OWN_I)
          drop_nxt = 1'b1;
        if (m_resp_valid) begin
          i_resp_valid = (owner == OWN_I) & ~drop;
          d_resp_valid = (owner == OWN_D);
          drop_nxt     = 1'b0;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Holding register loads only on the IDLE->REQ edge, so m_req_* stay stable while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner        <= OWN_I;
      m_req_addr   <= '0;
      m_req_write  <= 1'b0;
      m_req_size   <= '0;
      m_req_strobe <= '0;
      m_req_wdata  <= '0;
    end else if (state == S_IDLE && grant_any) begin
      if (grant_d) begin
        owner        <= OWN_D;
        m_req_addr   <= d_req_addr;
        m_req_write  <= d_req_write;
        m_req_size   <= d_req_size;
        m_req_strobe <= d_req_strobe;
        m_req_wdata  <= d_req_wdata;
      end else begin
        owner        <= OWN_I;
        m_req_addr   <= i_req_addr;
        m_req_write  <= 1'b0;
        m_req_size   <= 3'b010;
        m_req_strobe <= '0;
        m_req_wdata  <= '0;
      end
    end
  end

  assign i_resp_data = m_resp_data;
  assign d_resp_data = m_resp_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Table-driven cycle vectors for mem_bus_arbiter plus a hand-written async reset sequence.
module tb_mem_bus_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [63:0] A_I = 64'h0000_0000_8000_0000;
  localparam logic [63:0] A_D = 64'h0000_0000_8000_1000;
  localparam logic [63:0] WD  = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] RD  = 64'h0000_0000_0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [63:0] i_req_addr, i_resp_data;
  logic        d_req_valid, d_req_write, d_req_ready, d_resp_valid;
  logic [63:0] d_req_addr, d_req_wdata, d_resp_data;
  logic [2:0]  d_req_size;
  logic [7:0]  d_req_strobe;
  logic        flush;
  logic        m_req_valid, m_req_write, m_req_ready, m_resp_valid;
  logic [63:0] m_req_addr, m_req_wdata, m_resp_data;
  logic [2:0]  m_req_size;
  logic [7:0]  m_req_strobe;

  int checks = 0;
  int failures = 0;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_write(d_req_write),
    .d_req_size(d_req_size), .d_req_strobe(d_req_strobe), .d_req_wdata(d_req_wdata),
    .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .flush(flush),
    .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_write(m_req_write),
    .m_req_size(m_req_size), .m_req_strobe(m_req_strobe), .m_req_wdata(m_req_wdata),
    .m_req_ready(m_req_ready), .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        i_v, d_v, fl, rdy, rv;
    logic        e_irdy, e_drdy, e_mv, e_mw, e_irv, e_drv;
    logic [63:0] e_maddr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic i_v, d_v, fl, rdy, rv,
                     input logic e_irdy, e_drdy, e_mv, e_mw, e_irv, e_drv,
                     input logic [63:0] e_maddr);
    vec_t v;
    v.i_v = i_v; v.d_v = d_v; v.fl = fl; v.rdy = rdy; v.rv = rv;
    v.e_irdy = e_irdy; v.e_drdy = e_drdy; v.e_mv = e_mv; v.e_mw = e_mw;
    v.e_irv = e_irv; v.e_drv = e_drv; v.e_maddr = e_maddr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic i_v, d_v, fl, rdy, rv);
    i_req_valid  = i_v;
    d_req_valid  = d_v;
    flush        = fl;
    m_req_ready  = rdy;
    m_resp_valid = rv;
  endtask

  initial begin
    logic [63:0] x2;
    logic [2:0]  e_size;
    x2 = RR ? A_I : A_D;

    // lone fetch
    add(1,0,0,0,0, 1,0,0,0,0,0, 64'h0);
    add(0,0,0,1,0, 0,0,1,0,0,0, A_I);
    add(0,0,0,0,0, 0,0,0,0,0,0, A_I);
    add(0,0,0,0,1, 0,0,0,0,1,0, A_I);
    add(0,0,0,0,0, 0,0,0,0,0,0, A_I);
    // simultaneous I and D, then a second tie
    add(1,1,0,0,0, 0,1,0,0,0,0, A_I);
    add(1,0,0,1,0, 0,0,1,1,0,0, A_D);
    add(1,0,0,0,1, 0,0,0,1,0,1, A_D);
    add(1,1,0,0,0, RR,!RR,0,1,0,0, A_D);
    add(0,0,0,1,0, 0,0,1,!RR,0,0, x2);
    add(0,0,0,0,1, 0,0,0,!RR,RR,!RR, x2);
    // flush during WAIT of a fetch, then a normal fetch
    add(1,0,0,0,0, 1,0,0,!RR,0,0, x2);
    add(0,0,0,1,0, 0,0,1,0,0,0, A_I);
    add(0,0,1,0,0, 0,0,0,0,0,0, A_I);
    add(0,0,0,0,1, 0,0,0,0,0,0, A_I);
    add(1,0,0,0,0, 1,0,0,0,0,0, A_I);
    add(0,0,0,1,0, 0,0,1,0,0,0, A_I);
    add(0,0,0,0,1, 0,0,0,0,1,0, A_I);
    // flush in IDLE blocks the fetch grant
    add(1,0,1,0,0, 0,0,0,0,0,0, A_I);
    add(1,0,1,0,0, 0,0,0,0,0,0, A_I);
    add(1,0,0,0,0, 1,0,0,0,0,0, A_I);
    // bus stall 5 cycles with a waiting data request
    for (int i = 0; i < 5; i++)
      add(0,1,0,0,0, 0,0,1,0,0,0, A_I);
    add(0,1,0,1,0, 0,0,1,0,0,0, A_I);
    add(0,1,0,0,1, 0,0,0,0,1,0, A_I);
    add(0,1,0,0,0, 0,1,0,0,0,0, A_I);
    add(0,0,0,1,0, 0,0,1,1,0,0, A_D);
    add(0,0,0,0,0, 0,0,0,1,0,0, A_D);

    i_req_addr   = A_I;
    d_req_addr   = A_D;
    d_req_write  = 1'b1;
    d_req_size   = 3'b011;
    d_req_strobe = 8'hFF;
    d_req_wdata  = WD;
    m_resp_data  = RD;
    drive(0,0,0,0,0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_m_req_valid", {63'd0, m_req_valid}, 64'd0);
    chk("rst_m_req_addr", m_req_addr, 64'd0);
    chk("rst_i_req_ready", {63'd0, i_req_ready}, 64'd0);
    chk("rst_d_req_ready", {63'd0, d_req_ready}, 64'd0);
    reset = 1'b1;

    foreach (vq[n]) begin
      @(negedge clk);
      drive(vq[n].i_v, vq[n].d_v, vq[n].fl, vq[n].rdy, vq[n].rv);
      #2;
      e_size = (vq[n].e_maddr == 64'd0) ? 3'd0 : (vq[n].e_mw ? 3'd3 : 3'd2);
      chk($sformatf("v%0d_i_req_ready", n), {63'd0, i_req_ready}, {63'd0, vq[n].e_irdy});
      chk($sformatf("v%0d_d_req_ready", n), {63'd0, d_req_ready}, {63'd0, vq[n].e_drdy});
      chk($sformatf("v%0d_m_req_valid", n), {63'd0, m_req_valid}, {63'd0, vq[n].e_mv});
      chk($sformatf("v%0d_m_req_addr", n), m_req_addr, vq[n].e_maddr);
      chk($sformatf("v%0d_m_req_write", n), {63'd0, m_req_write}, {63'd0, vq[n].e_mw});
      chk($sformatf("v%0d_m_req_size", n), {61'd0, m_req_size}, {61'd0, e_size});
      chk($sformatf("v%0d_m_req_strobe", n), {56'd0, m_req_strobe}, vq[n].e_mw ? 64'hFF : 64'h0);
      chk($sformatf("v%0d_m_req_wdata", n), m_req_wdata, vq[n].e_mw ? WD : 64'h0);
      chk($sformatf("v%0d_i_resp_valid", n), {63'd0, i_resp_valid}, {63'd0, vq[n].e_irv});
      chk($sformatf("v%0d_d_resp_valid", n), {63'd0, d_resp_valid}, {63'd0, vq[n].e_drv});
      if (vq[n].e_irv) chk($sformatf("v%0d_i_resp_data", n), i_resp_data, RD);
      if (vq[n].e_drv) chk($sformatf("v%0d_d_resp_data", n), d_resp_data, RD);
    end

    // DUT now in WAIT for a store; reset asynchronously between edges
    @(negedge clk);
    drive(0,0,0,0,0);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_m_req_valid", {63'd0, m_req_valid}, 64'd0);
    chk("arst_m_req_addr", m_req_addr, 64'd0);
    chk("arst_m_req_write", {63'd0, m_req_write}, 64'd0);
    m_resp_valid = 1'b1;
    #1;
    chk("arst_d_resp_valid", {63'd0, d_resp_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("post_rst_d_resp_valid", {63'd0, d_resp_valid}, 64'd0);
    chk("post_rst_i_resp_valid", {63'd0, i_resp_valid}, 64'd0);
    @(negedge clk);
    drive(0,1,0,0,0);
    #2;
    chk("post_rst_d_req_ready", {63'd0, d_req_ready}, 64'd1);
    @(negedge clk);
    drive(0,0,0,1,0);
    #2;
    chk("post_rst_m_req_valid", {63'd0, m_req_valid}, 64'd1);
    chk("post_rst_m_req_addr", m_req_addr, A_D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
